scr1_tapc_upd_shift_reg: RTL and testbench



---
 rtl/scr1_tapc_upd_shift_reg_if.sv | 31 +++
 rtl/scr1_tapc_upd_shift_reg.sv | 85 ++++++++
 tb/tb_scr1_tapc_upd_shift_reg.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/scr1_tapc_upd_shift_reg_if.sv
// rtl/scr1_tapc_upd_shift_reg_if.sv - TAP-side command/data bundle for the update shift register
interface scr1_tapc_upd_shift_reg_if #(
    parameter int SCR1_WIDTH = 8
);
    localparam int CNT_W = $clog2(SCR1_WIDTH + 2);

    logic                  fsm_dr_select;
    logic                  fsm_dr_capture;
    logic                  fsm_dr_shift;
    logic                  fsm_dr_update;
    logic                  din_serial;
    logic [SCR1_WIDTH-1:0] din_parallel;
    logic                  dout_serial;
    logic [SCR1_WIDTH-1:0] dout_parallel;
    logic [SCR1_WIDTH-1:0] upd_data;
    logic                  upd_valid;
    logic                  upd_err;
    logic [CNT_W-1:0]      shift_cnt;

    modport master (
        output fsm_dr_select, fsm_dr_capture, fsm_dr_shift, fsm_dr_update,
        output din_serial, din_parallel,
        input  dout_serial, dout_parallel, upd_data, upd_valid, upd_err, shift_cnt
    );

    modport slave (
        input  fsm_dr_select, fsm_dr_capture, fsm_dr_shift, fsm_dr_update,
        input  din_serial, din_parallel,
        output dout_serial, dout_parallel, upd_data, upd_valid, upd_err, shift_cnt
    );
endinterface

// File: rtl/scr1_tapc_upd_shift_reg.sv
// rtl/scr1_tapc_upd_shift_reg.sv - JTAG data register with capture/shift stage and length-checked shadow update
module scr1_tapc_upd_shift_reg #(
    parameter int                    SCR1_WIDTH           = 8,
    parameter logic [SCR1_WIDTH-1:0] SCR1_RESET_VALUE     = '0,
    parameter logic [SCR1_WIDTH-1:0] SCR1_UPD_RESET_VALUE = '0,
    parameter bit                    SCR1_LSB_FIRST       = 1'b1,
    parameter bit                    SCR1_STRICT_LEN      = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    scr1_tapc_upd_shift_reg_if.slave dr
);
    localparam int               CNT_W    = $clog2(SCR1_WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SCR1_WIDTH);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SCR1_WIDTH + 1);

    logic [SCR1_WIDTH-1:0] shift_q;
    logic [SCR1_WIDTH-1:0] shift_next;
    logic [SCR1_WIDTH-1:0] upd_q;
    logic                  upd_valid_q;
    logic                  upd_err_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_inc;

    logic cmd_cap;
    logic cmd_sh;
    logic cmd_upd;
    logic len_ok;

    // Capture beats shift beats update; at most one acts per cycle.
    assign cmd_cap = dr.fsm_dr_select & dr.fsm_dr_capture;
    assign cmd_sh  = dr.fsm_dr_select & dr.fsm_dr_shift & ~dr.fsm_dr_capture;
    assign cmd_upd = dr.fsm_dr_select & dr.fsm_dr_update & ~dr.fsm_dr_capture & ~dr.fsm_dr_shift;

    assign len_ok  = (SCR1_STRICT_LEN == 1'b0) || (cnt_q == CNT_FULL);

    // Saturating at WIDTH+1 keeps an over-shift from wrapping back onto WIDTH.
    assign cnt_inc = (cnt_q == CNT_SAT) ? CNT_SAT : cnt_q + CNT_W'(1);

    generate
        if (SCR1_WIDTH == 1) begin : g_w1
            assign shift_next     = dr.din_serial;
            assign dr.dout_serial = shift_q[0];
        end else if (SCR1_LSB_FIRST) begin : g_lsb_first
            assign shift_next     = {dr.din_serial, shift_q[SCR1_WIDTH-1:1]};
            assign dr.dout_serial = shift_q[0];
        end else begin : g_msb_first
            assign shift_next     = {shift_q[SCR1_WIDTH-2:0], dr.din_serial};
            assign dr.dout_serial = shift_q[SCR1_WIDTH-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q     <= SCR1_RESET_VALUE;
            upd_q       <= SCR1_UPD_RESET_VALUE;
            upd_valid_q <= 1'b0;
            upd_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            upd_valid_q <= 1'b0;
            if (cmd_cap) begin
                shift_q   <= dr.din_parallel;
                cnt_q     <= '0;
                upd_err_q <= 1'b0;
            end else if (cmd_sh) begin
                shift_q <= shift_next;
                cnt_q   <= cnt_inc;
            end else if (cmd_upd) begin
                if (len_ok) begin
                    upd_q       <= shift_q;
                    upd_valid_q <= 1'b1;
                end else begin
                    upd_err_q <= 1'b1;
                end
            end
        end
    end

    assign dr.dout_parallel = shift_q;
    assign dr.upd_data      = upd_q;
    assign dr.upd_valid     = upd_valid_q;
    assign dr.upd_err       = upd_err_q;
    assign dr.shift_cnt     = cnt_q;
endmodule

// File: tb/tb_scr1_tapc_upd_shift_reg.sv
// tb/tb_scr1_tapc_upd_shift_reg.sv - vector table, corner sequences and random run against a reference model
module tb_scr1_tapc_upd_shift_reg;
    logic clk;
    logic r_rst, r_sel, r_cap, r_sh, r_upd, r_di;
    logic [7:0] r_dp;

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // a: 8b LSB-first strict; b: 8b LSB-first lax; c: 8b MSB-first strict; d: 1b strict
    scr1_tapc_upd_shift_reg_if #(.SCR1_WIDTH(8)) if_a ();
    scr1_tapc_upd_shift_reg_if #(.SCR1_WIDTH(8)) if_b ();
    scr1_tapc_upd_shift_reg_if #(.SCR1_WIDTH(8)) if_c ();
    scr1_tapc_upd_shift_reg_if #(.SCR1_WIDTH(1)) if_d ();

    scr1_tapc_upd_shift_reg #(.SCR1_WIDTH(8), .SCR1_RESET_VALUE(8'h3C), .SCR1_UPD_RESET_VALUE(8'h00),
        .SCR1_LSB_FIRST(1'b1), .SCR1_STRICT_LEN(1'b1)) dut_a (.clk(clk), .rst(r_rst), .dr(if_a));
    scr1_tapc_upd_shift_reg #(.SCR1_WIDTH(8), .SCR1_RESET_VALUE(8'h00), .SCR1_UPD_RESET_VALUE(8'h5A),
        .SCR1_LSB_FIRST(1'b1), .SCR1_STRICT_LEN(1'b0)) dut_b (.clk(clk), .rst(r_rst), .dr(if_b));
    scr1_tapc_upd_shift_reg #(.SCR1_WIDTH(8), .SCR1_RESET_VALUE(8'h00), .SCR1_UPD_RESET_VALUE(8'h00),
        .SCR1_LSB_FIRST(1'b0), .SCR1_STRICT_LEN(1'b1)) dut_c (.clk(clk), .rst(r_rst), .dr(if_c));
    scr1_tapc_upd_shift_reg #(.SCR1_WIDTH(1), .SCR1_RESET_VALUE(1'b1), .SCR1_UPD_RESET_VALUE(1'b0),
        .SCR1_LSB_FIRST(1'b1), .SCR1_STRICT_LEN(1'b1)) dut_d (.clk(clk), .rst(r_rst), .dr(if_d));

    assign if_a.fsm_dr_select = r_sel;  assign if_b.fsm_dr_select = r_sel;
    assign if_c.fsm_dr_select = r_sel;  assign if_d.fsm_dr_select = r_sel;
    assign if_a.fsm_dr_capture = r_cap; assign if_b.fsm_dr_capture = r_cap;
    assign if_c.fsm_dr_capture = r_cap; assign if_d.fsm_dr_capture = r_cap;
    assign if_a.fsm_dr_shift = r_sh;    assign if_b.fsm_dr_shift = r_sh;
    assign if_c.fsm_dr_shift = r_sh;    assign if_d.fsm_dr_shift = r_sh;
    assign if_a.fsm_dr_update = r_upd;  assign if_b.fsm_dr_update = r_upd;
    assign if_c.fsm_dr_update = r_upd;  assign if_d.fsm_dr_update = r_upd;
    assign if_a.din_serial = r_di;      assign if_b.din_serial = r_di;
    assign if_c.din_serial = r_di;      assign if_d.din_serial = r_di;
    assign if_a.din_parallel = r_dp;    assign if_b.din_parallel = r_dp;
    assign if_c.din_parallel = r_dp;    assign if_d.din_parallel = r_dp[0];

    logic [7:0] a_dp [4];
    logic [7:0] a_ud [4];
    logic [7:0] a_cnt[4];
    logic       a_ds [4];
    logic       a_v  [4];
    logic       a_err[4];

    assign a_dp[0] = if_a.dout_parallel; assign a_dp[1] = if_b.dout_parallel;
    assign a_dp[2] = if_c.dout_parallel; assign a_dp[3] = {7'b0, if_d.dout_parallel};
    assign a_ud[0] = if_a.upd_data;      assign a_ud[1] = if_b.upd_data;
    assign a_ud[2] = if_c.upd_data;      assign a_ud[3] = {7'b0, if_d.upd_data};
    assign a_cnt[0] = {4'b0, if_a.shift_cnt}; assign a_cnt[1] = {4'b0, if_b.shift_cnt};
    assign a_cnt[2] = {4'b0, if_c.shift_cnt}; assign a_cnt[3] = {6'b0, if_d.shift_cnt};
    assign a_ds[0] = if_a.dout_serial;   assign a_ds[1] = if_b.dout_serial;
    assign a_ds[2] = if_c.dout_serial;   assign a_ds[3] = if_d.dout_serial;
    assign a_v[0] = if_a.upd_valid;      assign a_v[1] = if_b.upd_valid;
    assign a_v[2] = if_c.upd_valid;      assign a_v[3] = if_d.upd_valid;
    assign a_err[0] = if_a.upd_err;      assign a_err[1] = if_b.upd_err;
    assign a_err[2] = if_c.upd_err;      assign a_err[3] = if_d.upd_err;

    // Reference model: register held as an integer, shifts as arithmetic
    int mw[4], mlsb[4], mstrict[4], mrv[4], murv[4];
    int m_sr[4], m_ud[4], m_cnt[4], m_v[4], m_err[4];

    task automatic model_step(input int i);
        int mask;
        mask = (1 << mw[i]) - 1;
        if (r_rst) begin
            m_sr[i] = mrv[i]; m_ud[i] = murv[i]; m_cnt[i] = 0; m_v[i] = 0; m_err[i] = 0;
        end else begin
            m_v[i] = 0;
            if (r_sel && r_cap) begin
                m_sr[i] = int'(r_dp) & mask; m_cnt[i] = 0; m_err[i] = 0;
            end else if (r_sel && r_sh) begin
                if (mlsb[i] != 0) m_sr[i] = (m_sr[i] >> 1) | (int'(r_di) << (mw[i] - 1));
                else              m_sr[i] = ((m_sr[i] << 1) | int'(r_di)) & mask;
                m_cnt[i] = (m_cnt[i] + 1 > mw[i] + 1) ? mw[i] + 1 : m_cnt[i] + 1;
            end else if (r_sel && r_upd) begin
                if (mstrict[i] == 0 || m_cnt[i] == mw[i]) begin
                    m_ud[i] = m_sr[i]; m_v[i] = 1;
                end else begin
                    m_err[i] = 1;
                end
            end
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            int exp_ds;
            model_step(i);
            exp_ds = (mlsb[i] != 0) ? (m_sr[i] & 1) : ((m_sr[i] >> (mw[i] - 1)) & 1);
            chk($sformatf("dut%0d dout_parallel", i), int'(a_dp[i]), m_sr[i]);
            chk($sformatf("dut%0d dout_serial", i), int'(a_ds[i]), exp_ds);
            chk($sformatf("dut%0d upd_data", i), int'(a_ud[i]), m_ud[i]);
            chk($sformatf("dut%0d upd_valid", i), int'(a_v[i]), m_v[i]);
            chk($sformatf("dut%0d upd_err", i), int'(a_err[i]), m_err[i]);
            chk($sformatf("dut%0d shift_cnt", i), int'(a_cnt[i]), m_cnt[i]);
        end
    endtask

    task automatic set_in(input bit r, input bit s, input bit c, input bit h, input bit u,
                          input bit di, input int dp);
        r_rst = r; r_sel = s; r_cap = c; r_sh = h; r_upd = u; r_di = di; r_dp = 8'(dp);
    endtask

    typedef struct {
        bit r, s, c, h, u, di;
        int dp;
        int e_dp, e_ds, e_ud, e_v, e_err, e_cnt;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input bit r, input bit s, input bit c, input bit h, input bit u, input bit di,
                       input int dp, input int e_dp, input int e_ds, input int e_ud,
                       input int e_v, input int e_err, input int e_cnt);
        vec_t v;
        v.r = r; v.s = s; v.c = c; v.h = h; v.u = u; v.di = di; v.dp = dp;
        v.e_dp = e_dp; v.e_ds = e_ds; v.e_ud = e_ud; v.e_v = e_v; v.e_err = e_err; v.e_cnt = e_cnt;
        tbl.push_back(v);
    endtask

    initial begin
        int exp_c_ser[8];
        mw      = '{8, 8, 8, 1};
        mlsb    = '{1, 1, 0, 1};
        mstrict = '{1, 0, 1, 1};
        mrv     = '{8'h3C, 0, 0, 1};
        murv    = '{0, 8'h5A, 0, 0};
        exp_c_ser = '{0, 0, 0, 0, 0, 0, 0, 1};

        //   r  s  c  h  u  di dp     | dp     ds ud     v  err cnt   (expectations for dut_a)
        add(1, 0, 0, 0, 0, 0, 0,       8'h3C, 0, 8'h00, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0,       8'h3C, 0, 8'h00, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 8'hA5,   8'hA5, 1, 8'h00, 0, 0, 0);
        add(0, 1, 0, 1, 0, 1, 0,       8'hD2, 0, 8'h00, 0, 0, 1);
        add(0, 1, 0, 1, 0, 0, 0,       8'h69, 1, 8'h00, 0, 0, 2);
        add(0, 1, 0, 1, 0, 0, 0,       8'h34, 0, 8'h00, 0, 0, 3);
        add(0, 1, 0, 1, 0, 0, 0,       8'h1A, 0, 8'h00, 0, 0, 4);
        add(0, 1, 0, 1, 0, 0, 0,       8'h0D, 1, 8'h00, 0, 0, 5);
        add(0, 1, 0, 1, 0, 0, 0,       8'h06, 0, 8'h00, 0, 0, 6);
        add(0, 1, 0, 1, 0, 0, 0,       8'h03, 1, 8'h00, 0, 0, 7);
        add(0, 1, 0, 1, 0, 1, 0,       8'h81, 1, 8'h00, 0, 0, 8);
        add(0, 1, 0, 0, 1, 0, 0,       8'h81, 1, 8'h81, 1, 0, 8);
        add(0, 1, 0, 0, 0, 0, 0,       8'h81, 1, 8'h81, 0, 0, 8);
        add(0, 1, 1, 0, 0, 0, 8'h5A,   8'h5A, 0, 8'h81, 0, 0, 0);
        add(0, 1, 0, 1, 0, 0, 0,       8'h2D, 1, 8'h81, 0, 0, 1);
        add(0, 1, 0, 1, 0, 0, 0,       8'h16, 0, 8'h81, 0, 0, 2);
        add(0, 1, 0, 1, 0, 0, 0,       8'h0B, 1, 8'h81, 0, 0, 3);
        add(0, 1, 0, 1, 0, 0, 0,       8'h05, 1, 8'h81, 0, 0, 4);
        add(0, 1, 0, 1, 0, 0, 0,       8'h02, 0, 8'h81, 0, 0, 5);
        add(0, 1, 0, 0, 1, 0, 0,       8'h02, 0, 8'h81, 0, 1, 5);
        add(0, 1, 1, 0, 0, 0, 8'h00,   8'h00, 0, 8'h81, 0, 0, 0);
        for (int k = 1; k <= 10; k++)
            add(0, 1, 0, 1, 0, 0, 0,   8'h00, 0, 8'h81, 0, 0, (k > 9) ? 9 : k);
        add(0, 1, 0, 0, 1, 0, 0,       8'h00, 0, 8'h81, 0, 1, 9);
        add(0, 1, 0, 1, 0, 0, 0,       8'h00, 0, 8'h81, 0, 1, 9);
        add(0, 1, 1, 0, 0, 0, 8'h11,   8'h11, 1, 8'h81, 0, 0, 0);
        add(0, 0, 1, 1, 1, 1, 8'hFF,   8'h11, 1, 8'h81, 0, 0, 0);
        add(0, 1, 1, 1, 0, 1, 8'h03,   8'h03, 1, 8'h81, 0, 0, 0);
        add(0, 1, 0, 1, 0, 1, 0,       8'h81, 1, 8'h81, 0, 0, 1);
        add(0, 1, 0, 1, 0, 1, 0,       8'hC0, 0, 8'h81, 0, 0, 2);
        add(0, 1, 0, 1, 0, 1, 0,       8'hE0, 0, 8'h81, 0, 0, 3);
        add(1, 1, 0, 1, 0, 1, 0,       8'h3C, 0, 8'h00, 0, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0,       8'h3C, 0, 8'h00, 0, 1, 0);

        foreach (tbl[n]) begin
            set_in(tbl[n].r, tbl[n].s, tbl[n].c, tbl[n].h, tbl[n].u, tbl[n].di, tbl[n].dp);
            step();
            chk($sformatf("vec%0d dout_parallel", n), int'(a_dp[0]), tbl[n].e_dp);
            chk($sformatf("vec%0d dout_serial", n), int'(a_ds[0]), tbl[n].e_ds);
            chk($sformatf("vec%0d upd_data", n), int'(a_ud[0]), tbl[n].e_ud);
            chk($sformatf("vec%0d upd_valid", n), int'(a_v[0]), tbl[n].e_v);
            chk($sformatf("vec%0d upd_err", n), int'(a_err[0]), tbl[n].e_err);
            chk($sformatf("vec%0d shift_cnt", n), int'(a_cnt[0]), tbl[n].e_cnt);
        end

        // Non-strict commit of a short shift
        set_in(0, 1, 1, 0, 0, 0, 8'hF0); step();
        for (int k = 0; k < 3; k++) begin set_in(0, 1, 0, 1, 0, 0, 0); step(); end
        set_in(0, 1, 0, 0, 1, 0, 0); step();
        chk("lax upd_data", int'(a_ud[1]), 8'h1E);
        chk("lax upd_valid", int'(a_v[1]), 1);
        chk("lax upd_err", int'(a_err[1]), 0);
        chk("strict short err", int'(a_err[0]), 1);
        set_in(0, 1, 0, 0, 1, 0, 0); step();
        chk("lax back-to-back upd_valid", int'(a_v[1]), 1);

        // MSB-first serial stream
        set_in(0, 1, 1, 0, 0, 0, 8'h01); step();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("msb dout_serial[%0d]", k), int'(a_ds[2]), exp_c_ser[k]);
            set_in(0, 1, 0, 1, 0, 1, 0); step();
        end
        chk("msb dout_parallel", int'(a_dp[2]), 8'hFF);

        // Single-bit register
        set_in(0, 1, 1, 0, 0, 0, 8'h01); step();
        chk("w1 dout_serial cap", int'(a_ds[3]), 1);
        set_in(0, 1, 0, 1, 0, 0, 0); step();
        chk("w1 dout_serial shift", int'(a_ds[3]), 0);
        set_in(0, 1, 0, 0, 1, 0, 0); step();
        chk("w1 upd_valid", int'(a_v[3]), 1);

        for (int k = 0; k < 3000; k++) begin
            set_in(($urandom % 64) == 0, ($urandom % 8) != 0, ($urandom % 12) == 0,
                   ($urandom % 3) != 0, ($urandom % 4) == 0, 1'($urandom), int'($urandom % 256));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
